// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and helpers for the arithmetic datapath units.
package arith_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ITER = 4'b0010,
        FIX  = 4'b0100,
        DONE = 4'b1000
    } div_state_e;

    // Two's-complement magnitude of the low w bits of x; the caller slices [w-1:0].
    function automatic logic [63:0] abs_w(input logic [63:0] x, input int w);
        return x[w-1] ? -x : x;
    endfunction

endpackage

// File: rtl/nr_addsub_step.sv
// nr_addsub_step: WIDTH+1 bit add/subtract of the partial remainder and divisor magnitude.
module nr_addsub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] m,
    input  logic             sub,
    output logic [WIDTH:0]   y
);

    assign y = sub ? a - {1'b0, m} : a + {1'b0, m};

endmodule

// File: rtl/nr_divider.sv
// nr_divider: multi-cycle non-restoring divider, signed/unsigned, with start/busy/done handshake.
module nr_divider
    import arith_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    div_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p, sh, step_a, step_y;
    logic [WIDTH-1:0] q, m, rem_mag, dvd_mag, dvs_mag;
    logic [63:0]      a_abs, b_abs;
    logic             q_neg, r_neg, ovf_l, step_sub, zero_div, last, accept;

    assign a_abs    = abs_w(64'(dividend), WIDTH);
    assign b_abs    = abs_w(64'(divisor), WIDTH);
    assign dvd_mag  = signed_mode ? a_abs[WIDTH-1:0] : dividend;
    assign dvs_mag  = signed_mode ? b_abs[WIDTH-1:0] : divisor;
    assign zero_div = divisor == '0;
    assign last     = cnt == CNT_W'(WIDTH - 1);
    assign accept   = state == IDLE && start;

    // The single adder does the per-iteration step in ITER and the final correction in FIX.
    assign sh       = {p[WIDTH-1:0], q[WIDTH-1]};
    assign step_a   = state == FIX ? p : sh;
    assign step_sub = state == FIX ? 1'b0 : ~p[WIDTH];
    assign rem_mag  = p[WIDTH] ? step_y[WIDTH-1:0] : p[WIDTH-1:0];

    nr_addsub_step #(.WIDTH(WIDTH)) u_step (
        .a   (step_a),
        .m   (m),
        .sub (step_sub),
        .y   (step_y)
    );

    assign busy = state == ITER || state == FIX;
    assign done = state == DONE;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (start ? (zero_div ? DONE : ITER) : IDLE) :
                    state == ITER ? (last ? FIX : ITER) :
                    state == FIX  ? DONE : IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            m           <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_l       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                p     <= '0;
                cnt   <= '0;
                q     <= dvd_mag;
                m     <= dvs_mag;
                q_neg <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg <= signed_mode & dividend[WIDTH-1];
                ovf_l <= signed_mode && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
                if (zero_div) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                end
            end else if (state == ITER) begin
                p   <= step_y;
                q   <= {q[WIDTH-2:0], ~step_y[WIDTH]};
                cnt <= cnt + CNT_W'(1);
            end else if (state == FIX) begin
                quotient    <= q_neg ? -q : q;
                remainder   <= (r_neg && rem_mag != '0) ? -rem_mag : rem_mag;
                div_by_zero <= 1'b0;
                overflow    <= ovf_l;
            end
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// tb_nr_divider: directed table-driven checks for nr_divider at WIDTH=32 and WIDTH=8.
module tb_nr_divider;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic        start, sm, busy, done, dbz, ovf;
    logic [31:0] a, b, q, r;
    logic        start8, sm8, busy8, done8, dbz8, ovf8;
    logic [7:0]  a8, b8, q8, r8;

    nr_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .signed_mode(sm),
        .dividend(a), .divisor(b), .busy(busy), .done(done),
        .quotient(q), .remainder(r), .div_by_zero(dbz), .overflow(ovf)
    );

    nr_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .overflow(ovf8)
    );

    typedef struct {
        logic        s;
        logic [31:0] a, b, q, r;
        logic        dz, ov;
        int          lat, bc;
    } vec_t;

    vec_t v[12];
    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_b && ((busy && done) || (busy8 && done8))) begin
            miscompares++;
            $display("FAIL busy_done_overlap: busy and done both high");
        end

    // Called just after a rising edge; lat counts edges from driving start until done is seen.
    task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bc, output int hold_err);
        logic [31:0] q_prev;
        q_prev = q;
        start = 1'b1; sm = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; bc = 0; hold_err = 0;
        while (!done && lat < 100) begin
            bc += int'(busy);
            if (busy && q !== q_prev) hold_err++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, he;
        start = 0; sm = 0; a = 0; b = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;

        v[0]  = '{1'b0, 32'd4802,     32'd172,        32'd27,         32'd158,        1'b0, 1'b0, 34, 33};
        v[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 34, 33};
        v[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 34, 33};
        v[3]  = '{1'b0, 32'd100,      32'd0,          32'hFFFFFFFF,   32'd100,        1'b1, 1'b0, 1,  0};
        v[4]  = '{1'b1, 32'd100,      32'd0,          32'hFFFFFFFF,   32'd100,        1'b1, 1'b0, 1,  0};
        v[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 34, 33};
        v[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0, 34, 33};
        v[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 1'b0, 34, 33};
        v[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 34, 33};
        v[9]  = '{1'b0, 32'd5,        32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 34, 33};
        v[10] = '{1'b1, 32'hFFFFFF9C, 32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1, 1'b0, 1,  0};
        v[11] = '{1'b0, 32'hFFFFFFFF, 32'd2,          32'h7FFFFFFF,   32'd1,          1'b0, 1'b0, 34, 33};

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_quotient", 64'(q), 64'd0);
        chk("reset_remainder", 64'(r), 64'd0);
        chk("reset_dbz", 64'(dbz), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run32(v[i].s, v[i].a, v[i].b, lat, bc, he);
            chk($sformatf("v%0d_quotient", i), 64'(q), 64'(v[i].q));
            chk($sformatf("v%0d_remainder", i), 64'(r), 64'(v[i].r));
            chk($sformatf("v%0d_dbz", i), 64'(dbz), 64'(v[i].dz));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(v[i].ov));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(v[i].bc));
            chk($sformatf("v%0d_outputs_held", i), 64'(he), 64'd0);
            @(posedge clk); #1;
        end

        // 8-bit: 255/1 with a second start pulsed mid-operation that must be ignored.
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd255; b8 = 8'd1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8(lat);
        chk("w8_255_quotient", 64'(q8), 64'd255);
        chk("w8_255_remainder", 64'(r8), 64'd0);
        chk("w8_255_latency", 64'(lat + 5), 64'd10);
        repeat (3) begin @(posedge clk); #1; end
        chk("w8_ignored_start_busy", 64'(busy8), 64'd0);
        chk("w8_ignored_start_q", 64'(q8), 64'd255);

        // 200/7, with start raised during the done cycle (must be ignored).
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8(lat);
        chk("w8_200_quotient", 64'(q8), 64'd28);
        chk("w8_200_remainder", 64'(r8), 64'd4);
        chk("w8_200_latency", 64'(lat + 1), 64'd10);
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("w8_start_on_done_busy", 64'(busy8), 64'd0);
        chk("w8_start_on_done_q", 64'(q8), 64'd28);

        // Reset five cycles into a 32-bit operation.
        start = 1'b1; sm = 1'b0; a = 32'd4802; b = 32'd172;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("mid_busy_before_reset", 64'(busy), 64'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_reset_busy", 64'(busy), 64'd0);
        chk("mid_reset_quotient", 64'(q), 64'd0);
        chk("mid_reset_remainder", 64'(r), 64'd0);
        chk("mid_reset_flags", 64'({dbz, ovf}), 64'd0);
        bc = 0;
        repeat (5) begin @(posedge clk); #1; bc += int'(done); end
        chk("mid_reset_no_done", 64'(bc), 64'd0);
        rst_b = 1'b1;
        bc = 0;
        repeat (40) begin @(posedge clk); #1; bc += int'(done); end
        chk("after_reset_no_done", 64'(bc), 64'd0);
        run32(1'b0, 32'd4802, 32'd172, lat, bc, he);
        chk("after_reset_quotient", 64'(q), 64'd27);
        chk("after_reset_remainder", 64'(r), 64'd158);
        chk("after_reset_latency", 64'(lat), 64'd34);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
